load_store_unit: RTL and testbench



---
 rtl/mem_pkg.sv | 33 +++
 rtl/byte_lane_unit.sv | 43 ++++
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store unit.
package mem_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      SIZE_BYTE    = 2'b00,
      SIZE_HALF    = 2'b01,
      SIZE_WORD    = 2'b10,
      SIZE_ILLEGAL = 2'b11
   } mem_size_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } lsu_state_t;

   // Alignment check only; the illegal size code is screened separately.
   function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (size)
         SIZE_HALF: mis = addr_lo[0];
         SIZE_WORD: mis = (addr_lo != 2'b00);
         default:   mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: extracts/extends load data and merges sub-word
// store data into a read word. The same instance serves loads and stores.
module byte_lane_unit
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  lane,
   input  logic [31:0] ram_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = ram_word[{lane, 3'b000} +: 8];
   assign half_sel = ram_word[{lane[1], 4'b0000} +: 16];

   // Select lane, extend for loads, splice store data into the read word.
   always_comb begin
      load_data   = ram_word;
      merged_word = store_data;
      case (mem_size_t'(size))
         SIZE_BYTE: begin
            load_data   = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            merged_word = ram_word;
            merged_word[{lane, 3'b000} +: 8] = store_data[7:0];
         end
         SIZE_HALF: begin
            load_data   = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            merged_word = ram_word;
            merged_word[{lane[1], 4'b0000} +: 16] = store_data[15:0];
         end
         default: begin
            load_data   = ram_word;
            merged_word = store_data;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU requests into aligned word
// accesses on a synchronous-read, word-write RAM. Sub-word stores are done
// as read-modify-write; misaligned or illegal requests return a fault.
module load_store_unit
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_fault,
   output logic                  ram_write_enable,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [31:0]           ram_in,
   input  logic [31:0]           ram_out
);

   lsu_state_t            state_q, state_d;
   logic                  write_q;
   logic [1:0]            size_q;
   logic                  unsigned_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic                  fault_q;
   logic [31:0]           rdata_q;
   logic [31:0]           ram_in_q;

   logic                  accept;
   logic                  req_fault;
   logic                  req_is_sw;
   logic [31:0]           lane_load;
   logic [31:0]           lane_merge;

   assign accept    = req_valid && req_ready;
   assign req_fault = (req_size == SIZE_ILLEGAL) ||
                      is_misaligned(mem_size_t'(req_size), req_address[1:0]);
   assign req_is_sw = req_write && (req_size == SIZE_WORD);

   byte_lane_unit u_lane (
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .lane        (addr_q[1:0]),
      .ram_word    (ram_out),
      .store_data  (wdata_q),
      .load_data   (lane_load),
      .merged_word (lane_merge)
   );

   // State register; reset aborts any access in flight, including a pending write.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: faults go straight to RESP, sw skips the read phase.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_fault) begin
                  state_d = RESP;
               end else if (req_is_sw) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD:      state_d = WAIT;
         WAIT:    state_d = write_q ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state; RAM writes happen only in WR.
   always_comb begin
      req_ready        = (state_q == IDLE);
      resp_valid       = (state_q == RESP);
      ram_write_enable = (state_q == WR);
   end

   // Masking only: the aligned address never wraps.
   assign ram_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign ram_in      = ram_in_q;
   assign resp_rdata  = rdata_q;
   assign resp_fault  = fault_q;

   // Request latch on accept; WAIT captures either load data or merged word.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         write_q    <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
         fault_q    <= 1'b0;
         rdata_q    <= 32'h0;
         ram_in_q   <= 32'h0;
      end else if (accept) begin
         write_q    <= req_write;
         size_q     <= req_size;
         unsigned_q <= req_unsigned;
         addr_q     <= req_address;
         wdata_q    <= req_wdata;
         fault_q    <= req_fault;
         rdata_q    <= 32'h0;
         if (req_is_sw) begin
            ram_in_q <= req_wdata;
         end
      end else if (state_q == WAIT) begin
         if (write_q) begin
            ram_in_q <= lane_merge;
         end else begin
            rdata_q <= lane_load;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural synchronous RAM.
module tb_load_store_unit;

   logic        clock;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_address;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        ram_write_enable;
   logic [31:0] ram_address;
   logic [31:0] ram_in;
   logic [31:0] ram_out;

   typedef struct {
      logic [31:0] data;
      logic        fault;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   logic [31:0] mem [0:15];

   load_store_unit #(.ADDR_WIDTH(32)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_size         (req_size),
      .req_unsigned     (req_unsigned),
      .req_address      (req_address),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .resp_fault       (resp_fault),
      .ram_write_enable (ram_write_enable),
      .ram_address      (ram_address),
      .ram_in           (ram_in),
      .ram_out          (ram_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM model: word writes, read data one cycle after the address.
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      ram_out = 32'h0;
   end
   always @(posedge clock) begin
      if (ram_write_enable) mem[ram_address[5:2]] <= ram_in;
      ram_out <= mem[ram_address[5:2]];
   end

   // One request: push expectation at accept, pop and compare at response.
   task automatic do_req(input string name, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_data, input logic exp_fault,
                         input int exp_lat, input int exp_we, input logic [31:0] exp_wword);
      int   waited;
      int   lat;
      int   we_cnt;
      bit   got;
      exp_t e;
      @(negedge clock);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_address = a; req_wdata = wd;
      waited = 0;
      while (!req_ready && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL %s accept: req_ready=%0b after %0d cycles, required 1", name, req_ready, waited);
         req_valid = 1'b0;
         return;
      end
      exp_q.push_back('{exp_data, exp_fault, exp_lat});
      @(posedge clock);
      #1 req_valid = 1'b0;
      lat = 0; we_cnt = 0; got = 0;
      for (int c = 1; c <= 12 && !got; c++) begin
         @(negedge clock);
         if (ram_write_enable) begin
            we_cnt++;
            checks++;
            if (ram_address !== {a[31:2], 2'b00} || ram_in !== exp_wword) begin
               errors++;
               $display("FAIL %s write: addr=%h data=%h, required addr=%h data=%h",
                        name, ram_address, ram_in, {a[31:2], 2'b00}, exp_wword);
            end
         end
         if (resp_valid) begin
            got = 1;
            lat = c;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s response: no resp_valid within 12 cycles, required one", name);
         void'(exp_q.pop_front());
         return;
      end
      e = exp_q.pop_front();
      if (resp_rdata !== e.data || resp_fault !== e.fault || lat != e.lat) begin
         errors++;
         $display("FAIL %s resp: rdata=%h fault=%0b lat=%0d, required rdata=%h fault=%0b lat=%0d",
                  name, resp_rdata, resp_fault, lat, e.data, e.fault, e.lat);
      end
      checks++;
      if (we_cnt != exp_we) begin
         errors++;
         $display("FAIL %s write_count: %0d, required %0d", name, we_cnt, exp_we);
      end
      $display("txn %-12s addr=%h rdata=%h fault=%0b lat=%0d writes=%0d",
               name, a, resp_rdata, resp_fault, lat, we_cnt);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_address = 32'h0; req_wdata = 32'h0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_fault !== 1'b0 ||
          ram_write_enable !== 1'b0 || ram_address !== 32'h0 || ram_in !== 32'h0) begin
         errors++;
         $display("FAIL reset: ready=%0b rv=%0b rd=%h f=%0b we=%0b ra=%h ri=%h, required 1 0 0 0 0 0 0",
                  req_ready, resp_valid, resp_rdata, resp_fault, ram_write_enable, ram_address, ram_in);
      end
      $display("txn reset       ready=%0b resp_valid=%0b", req_ready, resp_valid);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_word();
      do_req("sw_4", 1'b1, 2'b10, 1'b0, 32'h4, 32'h8899AABB, 32'h0, 1'b0, 2, 1, 32'h8899AABB);
      do_req("lw_4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 3, 0, 32'h0);
   endtask

   task automatic test_subword_load();
      do_req("lb_5",  1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 0, 32'h0);
      do_req("lbu_5", 1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 32'h000000AA, 1'b0, 3, 0, 32'h0);
      do_req("lh_6",  1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'hFFFF8899, 1'b0, 3, 0, 32'h0);
      do_req("lhu_6", 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'h00008899, 1'b0, 3, 0, 32'h0);
      do_req("lbu_4", 1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 32'h000000BB, 1'b0, 3, 0, 32'h0);
   endtask

   task automatic test_subword_store();
      do_req("sb_7", 1'b1, 2'b00, 1'b0, 32'h7, 32'hFFFFFF11, 32'h0, 1'b0, 4, 1, 32'h1199AABB);
      do_req("sh_4", 1'b1, 2'b01, 1'b1, 32'h4, 32'hABCD1234, 32'h0, 1'b0, 4, 1, 32'h11991234);
      do_req("lw_4b", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h11991234, 1'b0, 3, 0, 32'h0);
   endtask

   task automatic test_faults();
      do_req("lw_6_f",  1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
      do_req("lh_5_f",  1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
      do_req("sz3_8_f", 1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
      do_req("sw_2_f",  1'b1, 2'b10, 1'b0, 32'h2, 32'hDEADBEEF, 32'h0, 1'b1, 1, 0, 32'h0);
   endtask

   task automatic test_back_to_back();
      int   accepted;
      int   resp_cnt;
      bit   drop;
      exp_t e;
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_address = 32'h4; req_wdata = 32'h0;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b idle_ready: %0b, required 1", req_ready);
      end
      exp_q.push_back('{32'h11991234, 1'b0, 3});
      accepted = 1; resp_cnt = 0; drop = 0;
      @(posedge clock);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         if (c <= 3) begin
            checks++;
            if (req_ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b busy_ready c=%0d: %0b, required 0", c, req_ready);
            end
         end
         if (resp_valid) begin
            resp_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL b2b extra_resp c=%0d: unexpected resp_valid", c);
            end else begin
               e = exp_q.pop_front();
               if (resp_rdata !== e.data || resp_fault !== e.fault) begin
                  errors++;
                  $display("FAIL b2b resp c=%0d: rdata=%h fault=%0b, required rdata=%h fault=%0b",
                           c, resp_rdata, resp_fault, e.data, e.fault);
               end
            end
         end
         if (req_valid && req_ready) begin
            checks++;
            if (c != 4) begin
               errors++;
               $display("FAIL b2b second_accept: cycle %0d, required 4", c);
            end
            exp_q.push_back('{32'h11991234, 1'b0, 3});
            accepted++;
            drop = 1;
         end
         if (drop) begin
            @(posedge clock);
            #1 req_valid = 1'b0;
            drop = 0;
         end
      end
      checks++;
      if (resp_cnt != 2 || accepted != 2) begin
         errors++;
         $display("FAIL b2b counts: resp=%0d accepted=%0d, required 2 2", resp_cnt, accepted);
      end
      exp_q.delete();
      $display("txn b2b_lw      accepted=%0d responses=%0d", accepted, resp_cnt);
   endtask

   task automatic test_reset_midop();
      int we_cnt;
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_address = 32'h4; req_wdata = 32'h77;
      @(posedge clock);
      #1 req_valid = 1'b0;
      @(negedge clock);   // RD
      @(negedge clock);   // WAIT
      reset_n = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || ram_write_enable !== 1'b0 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_midop state: ready=%0b we=%0b rv=%0b, required 1 0 0",
                  req_ready, ram_write_enable, resp_valid);
      end
      we_cnt = 0;
      repeat (3) begin
         @(negedge clock);
         if (ram_write_enable) we_cnt++;
      end
      reset_n = 1'b1;
      repeat (2) begin
         @(negedge clock);
         if (ram_write_enable) we_cnt++;
      end
      checks++;
      if (we_cnt != 0) begin
         errors++;
         $display("FAIL reset_midop writes: %0d, required 0", we_cnt);
      end
      $display("txn sb_abort    writes=%0d", we_cnt);
      do_req("lw_4c", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h11991234, 1'b0, 3, 0, 32'h0);
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword_load();
      test_subword_store();
      test_faults();
      test_back_to_back();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
